// File: rtl/string_engine.sv
// Byte-string buffer with character access, case conversion and atoi/itoa commands.
// Commands arrive over a valid/ready port and each one ends with a single-cycle rsp_valid pulse.
module string_engine #(
  parameter int MAXLEN = 32,
  parameter int VAL_W  = 32,
  parameter int LW     = $clog2(MAXLEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_radix,
  input  logic [LW-1:0]    cmd_idx,
  input  logic [7:0]       cmd_char,
  input  logic [VAL_W-1:0] cmd_val,
  output logic             rsp_valid,
  output logic [VAL_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic [LW-1:0]    len
);

  // The buffer is rounded up to a power of two so every truncated index stays in range.
  localparam int AW    = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    OP_CLEAR, OP_APPEND, OP_PUTC, OP_GETC, OP_UPPER, OP_LOWER, OP_ATOI, OP_ITOA
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_CASE, S_EMIT} state_e;

  state_e           state_q, state_d;
  op_e              op;
  logic [7:0]       str_q [DEPTH];
  logic [LW-1:0]    idx_q, idx_nx;
  logic [VAL_W-1:0] acc_q, acc_nx, quo;
  logic [1:0]       radix_q;
  logic             upper_q;
  logic             accept, rsp_fire, rsp_err_d;
  logic [VAL_W-1:0] rsp_data_d;
  logic [7:0]       cur_char, nxt_char, emit_char;
  logic [3:0]       emit_dig;
  logic [4:0]       cur_dig, nxt_dig, first_dig;
  logic             idx_ok, putc_ok, append_err;

  // Returns {valid, value} for one character in the given radix.
  function automatic logic [4:0] digit_of(input logic [7:0] c, input logic [1:0] radix);
    logic [3:0] v;
    logic       ok;
    v  = 4'd0;
    ok = 1'b1;
    if (c >= 8'h30 && c <= 8'h39) v = c[3:0];
    else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46)) v = c[3:0] + 4'd9;
    else ok = 1'b0;
    case (radix)
      2'd0:    ok = ok && (v < 4'd2);
      2'd1:    ok = ok && (v < 4'd8);
      2'd2:    ok = ok && (v < 4'd10);
      default: ;
    endcase
    return {ok, v};
  endfunction

  function automatic logic [VAL_W-1:0] scale(input logic [VAL_W-1:0] a, input logic [1:0] radix);
    case (radix)
      2'd0:    return a << 1;
      2'd1:    return a << 3;
      2'd2:    return (a << 3) + (a << 1);
      default: return a << 4;
    endcase
  endfunction

  function automatic logic [7:0] conv_case(input logic [7:0] c, input logic up);
    if (up && c >= 8'h61 && c <= 8'h7a)  return c - 8'h20;
    if (!up && c >= 8'h41 && c <= 8'h5a) return c + 8'h20;
    return c;
  endfunction

  assign op         = op_e'(cmd_op);
  assign cmd_ready  = (state_q == S_IDLE) && !rsp_valid;
  assign accept     = cmd_valid && cmd_ready;
  assign idx_ok     = cmd_idx < len;
  assign putc_ok    = idx_ok && (cmd_char != 8'h00);
  assign append_err = (len == LW'(MAXLEN)) || (cmd_char == 8'h00);
  assign idx_nx     = idx_q + LW'(1);
  assign cur_char   = str_q[idx_q[AW-1:0]];
  assign nxt_char   = (idx_nx < len) ? str_q[idx_nx[AW-1:0]] : 8'h00;
  assign cur_dig    = digit_of(cur_char, radix_q);
  assign nxt_dig    = digit_of(nxt_char, radix_q);
  assign first_dig  = digit_of(str_q[0], cmd_radix);
  assign acc_nx     = scale(acc_q, radix_q) + VAL_W'(cur_dig[3:0]);

  // One itoa step: lowest digit of the remaining value and the value left over.
  always_comb begin
    emit_dig = 4'd0;
    quo      = acc_q;
    case (radix_q)
      2'd0: begin emit_dig = {3'd0, acc_q[0]};   quo = acc_q >> 1; end
      2'd1: begin emit_dig = {1'b0, acc_q[2:0]}; quo = acc_q >> 3; end
      2'd2: begin
        quo      = acc_q / VAL_W'(10);
        emit_dig = 4'(acc_q - quo * VAL_W'(10));
      end
      default: begin emit_dig = acc_q[3:0]; quo = acc_q >> 4; end
    endcase
    emit_char = (emit_dig < 4'd10) ? 8'h30 + {4'd0, emit_dig} : 8'h57 + {4'd0, emit_dig};
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    rsp_fire   = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_data_d = '0;
    case (state_q)
      S_IDLE: if (accept) begin
        case (op)
          OP_CLEAR:  rsp_fire = 1'b1;
          OP_APPEND: begin rsp_fire = 1'b1; rsp_err_d = append_err; end
          OP_PUTC:   begin rsp_fire = 1'b1; rsp_err_d = !putc_ok; end
          OP_GETC: begin
            rsp_fire   = 1'b1;
            rsp_err_d  = !idx_ok;
            rsp_data_d = idx_ok ? VAL_W'(str_q[cmd_idx[AW-1:0]]) : '0;
          end
          OP_UPPER, OP_LOWER: begin
            if (len == '0) rsp_fire = 1'b1;
            else           state_d  = S_CASE;
          end
          OP_ATOI: begin
            if (len == '0 || !first_dig[4]) rsp_fire = 1'b1;
            else                            state_d  = S_SCAN;
          end
          default: state_d = S_EMIT;
        endcase
      end
      // Stop when the next character is absent or not a digit, so the last digit and the
      // response share a cycle.
      S_SCAN: if (idx_nx == len || !nxt_dig[4]) begin
        rsp_fire   = 1'b1;
        rsp_data_d = acc_nx;
        state_d    = S_IDLE;
      end
      S_CASE: if (idx_nx == len) begin
        rsp_fire = 1'b1;
        state_d  = S_IDLE;
      end
      default: if (quo == '0) begin
        rsp_fire = 1'b1;
        state_d  = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len       <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      radix_q   <= 2'd0;
      upper_q   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      // NOTE: the string store is reset too, so a fresh engine always reads back zeros.
      for (int i = 0; i < DEPTH; i++) str_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      rsp_valid <= rsp_fire;
      if (rsp_fire) begin
        rsp_data <= rsp_data_d;
        rsp_err  <= rsp_err_d;
      end
      case (state_q)
        S_IDLE: if (accept) begin
          idx_q   <= '0;
          radix_q <= cmd_radix;
          upper_q <= (op == OP_UPPER);
          case (op)
            OP_CLEAR: len <= '0;
            OP_APPEND: if (!append_err) begin
              str_q[len[AW-1:0]] <= cmd_char;
              len                <= len + LW'(1);
            end
            OP_PUTC: if (putc_ok) str_q[cmd_idx[AW-1:0]] <= cmd_char;
            OP_ATOI: acc_q <= '0;
            OP_ITOA: begin
              acc_q <= cmd_val;
              len   <= '0;
            end
            default: ;
          endcase
        end
        S_SCAN: begin
          acc_q <= acc_nx;
          idx_q <= idx_nx;
        end
        S_CASE: begin
          str_q[idx_q[AW-1:0]] <= conv_case(cur_char, upper_q);
          idx_q                <= idx_nx;
        end
        default: begin
          // Digits come out least significant first; shifting up leaves the number in order.
          for (int i = DEPTH - 1; i > 0; i--) str_q[i] <= str_q[i-1];
          str_q[0] <= emit_char;
          len      <= len + LW'(1);
          acc_q    <= quo;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_string_engine.sv
// Scoreboard bench for string_engine: each command pushes its expected response,
// which the monitor pops and compares when rsp_valid pulses.
module tb_string_engine;

  localparam int MAXLEN = 32;
  localparam int VAL_W  = 32;
  localparam int LW     = $clog2(MAXLEN + 1);

  localparam logic [2:0] CLEAR = 3'd0, APPEND = 3'd1, PUTC = 3'd2, GETC = 3'd3,
                         UPPER = 3'd4, LOWER = 3'd5, ATOI = 3'd6, ITOA = 3'd7;
  localparam logic [1:0] BIN = 2'd0, OCT = 2'd1, DEC = 2'd2, HEX = 2'd3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd_op;
  logic [1:0]       cmd_radix;
  logic [LW-1:0]    cmd_idx;
  logic [7:0]       cmd_char;
  logic [VAL_W-1:0] cmd_val;
  logic             rsp_valid, rsp_err;
  logic [VAL_W-1:0] rsp_data;
  logic [LW-1:0]    len;

  string_engine #(.MAXLEN(MAXLEN), .VAL_W(VAL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_radix(cmd_radix),
    .cmd_idx(cmd_idx), .cmd_char(cmd_char), .cmd_val(cmd_val),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .len(len)
  );

  typedef struct {
    string            tag;
    logic [VAL_W-1:0] data;
    logic             err;
    int               lat;
    int               len;
    int               acc;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  e;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  string model_s;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic string itoa_ref(input logic [VAL_W-1:0] v, input logic [1:0] r);
    case (r)
      BIN:     return $sformatf("%0b", v);
      OCT:     return $sformatf("%0o", v);
      DEC:     return $sformatf("%0d", v);
      default: return $sformatf("%0h", v);
    endcase
  endfunction

  // Response monitor: latency counts from the accepting edge (1 = pulse right after it).
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.tag, "_data"}, 64'(rsp_data), 64'(e.data));
        check({e.tag, "_err"}, 64'(rsp_err), 64'(e.err));
        check({e.tag, "_lat"}, 64'(cyc - e.acc + 1), 64'(e.lat));
        check({e.tag, "_len"}, 64'(len), 64'(e.len));
        check({e.tag, "_busy"}, 64'(cmd_ready), 64'd0);
      end
    end
  end

  task automatic cmd(input string tag, input logic [2:0] op, input logic [1:0] r, input int idx,
                     input logic [7:0] ch, input logic [VAL_W-1:0] val,
                     input logic [VAL_W-1:0] e_data, input logic e_err, input int e_lat,
                     input int e_len, input bit hold = 1'b0);
    exp_t x;
    int   waited;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check({tag, "_ready_timeout"}, 64'd0, 64'd1);
      return;
    end
    cmd_op    = op;
    cmd_radix = r;
    cmd_idx   = LW'(idx);
    cmd_char  = ch;
    cmd_val   = val;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    x.tag  = tag;
    x.data = e_data;
    x.err  = e_err;
    x.lat  = e_lat;
    x.len  = e_len;
    x.acc  = cyc;
    exp_q.push_back(x);
    if (hold) begin
      // Keep offering an APPEND while busy; it must be ignored.
      cmd_op   = APPEND;
      cmd_char = 8'h21;
    end else begin
      cmd_valid = 1'b0;
    end
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    cmd_valid = 1'b0;
    if (exp_q.size() != 0) begin
      check({tag, "_rsp_timeout"}, 64'd0, 64'd1);
      exp_q.delete();
    end
  endtask

  task automatic clear_str();
    cmd("clear", CLEAR, DEC, 0, 8'h00, '0, '0, 1'b0, 1, 0);
    model_s = "";
  endtask

  task automatic append_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      cmd($sformatf("append_%s_%0d", s, i), APPEND, DEC, 0, s[i], '0, '0, 1'b0, 1,
          model_s.len() + 1);
      model_s = {model_s, s.substr(i, i)};
    end
  endtask

  task automatic verify(input string tag);
    for (int i = 0; i < model_s.len(); i++) begin
      logic [7:0] c;
      c = model_s[i];
      cmd($sformatf("%s_getc%0d", tag, i), GETC, DEC, i, 8'h00, '0, VAL_W'(c), 1'b0, 1,
          model_s.len());
    end
  endtask

  task automatic do_itoa(input string tag, input logic [VAL_W-1:0] v, input logic [1:0] r);
    string s;
    s = itoa_ref(v, r);
    cmd(tag, ITOA, r, 0, 8'h00, v, '0, 1'b0, 1 + s.len(), s.len());
    model_s = s;
    verify(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_radix = '0;
    cmd_idx   = '0;
    cmd_char  = '0;
    cmd_val   = '0;
    model_s   = "";
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_len", 64'(len), 64'd0);

    // Character access and its error cases.
    append_str("1234");
    cmd("putc_oob", PUTC, DEC, 4, 8'h7a, '0, '0, 1'b1, 1, 4);
    cmd("putc_nul", PUTC, DEC, 2, 8'h00, '0, '0, 1'b1, 1, 4);
    verify("s1234");
    cmd("putc_ok", PUTC, DEC, 2, 8'h7a, '0, '0, 1'b0, 1, 4);
    model_s[2] = 8'h7a;
    cmd("getc2", GETC, DEC, 2, 8'h00, '0, 32'h7a, 1'b0, 1, 4);
    cmd("getc_oob", GETC, DEC, 4, 8'h00, '0, '0, 1'b1, 1, 4);
    cmd("getc0", GETC, DEC, 0, 8'h00, '0, 32'h31, 1'b0, 1, 4);
    verify("s12z4");

    // Case conversion, with a command held on the port while busy.
    clear_str();
    append_str("ab7CD");
    cmd("upper", UPPER, DEC, 0, 8'h00, '0, '0, 1'b0, 6, 5, 1'b1);
    model_s = model_s.toupper();
    verify("up");
    cmd("lower", LOWER, DEC, 0, 8'h00, '0, '0, 1'b0, 6, 5);
    model_s = model_s.tolower();
    verify("lo");

    // Text to integer.
    clear_str();
    append_str("101");
    cmd("atoi_dec", ATOI, DEC, 0, 8'h00, '0, 32'd101, 1'b0, 4, 3);
    cmd("atoi_hex", ATOI, HEX, 0, 8'h00, '0, 32'h101, 1'b0, 4, 3);
    cmd("atoi_oct", ATOI, OCT, 0, 8'h00, '0, 32'o101, 1'b0, 4, 3);
    cmd("atoi_bin", ATOI, BIN, 0, 8'h00, '0, 32'd5, 1'b0, 4, 3);
    clear_str();
    append_str("12x4");
    cmd("atoi_stop", ATOI, DEC, 0, 8'h00, '0, 32'd12, 1'b0, 3, 4);
    clear_str();
    append_str("AbZ");
    cmd("atoi_hexcase", ATOI, HEX, 0, 8'h00, '0, 32'hab, 1'b0, 3, 3);
    cmd("atoi_bad_first", ATOI, OCT, 0, 8'h00, '0, '0, 1'b0, 1, 3);
    clear_str();
    append_str("fffffffff");
    cmd("atoi_wrap", ATOI, HEX, 0, 8'h00, '0, 32'hffffffff, 1'b0, 10, 9);
    clear_str();
    cmd("atoi_empty", ATOI, DEC, 0, 8'h00, '0, '0, 1'b0, 1, 0);
    cmd("upper_empty", UPPER, DEC, 0, 8'h00, '0, '0, 1'b0, 1, 0);

    // Integer to text.
    do_itoa("itoa_dec", 32'd123, DEC);
    do_itoa("itoa_hex", 32'd123, HEX);
    do_itoa("itoa_oct", 32'd123, OCT);
    do_itoa("itoa_bin", 32'd123, BIN);
    do_itoa("itoa_zero", 32'd0, DEC);
    do_itoa("itoa_max_dec", 32'hffffffff, DEC);
    do_itoa("itoa_max_bin", 32'hffffffff, BIN);
    cmd("append_full", APPEND, DEC, 0, 8'h71, '0, '0, 1'b1, 1, MAXLEN);

    // Reset in the middle of a long conversion.
    @(negedge clk);
    cmd_op    = ITOA;
    cmd_radix = BIN;
    cmd_val   = 32'hffffffff;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy", 64'(cmd_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_len", 64'(len), 64'd0);
    check("abort_ready", 64'(cmd_ready), 64'd1);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    model_s = "";
    repeat (40) @(negedge clk);
    #1;
    check("abort_len_after", 64'(len), 64'd0);
    check("abort_ready_after", 64'(cmd_ready), 64'd1);
    append_str("7");
    verify("post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
